// File: rtl/firmware_config_sender.sv
// Staging table of firmware bytes plus an FSM that broadcasts it to units over configId/configData.
// Build option: define CFG_SEND_DIRTY_ONLY_EN to send only units written since their last transmission.

module firmware_config_sender #(
  parameter int         NUM_UNITS  = 4,
  parameter int         MAX_CHAINS = 4,
  parameter logic [7:0] IDLE_ID    = 8'hFF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [7:0]                    wr_unit,
  input  logic [$clog2(MAX_CHAINS)-1:0] wr_chain,
  input  logic [7:0]                    wr_data,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic                          tracing,
  output logic [7:0]                    configId,
  output logic [7:0]                    configData
);

  // NUM_UNITS and MAX_CHAINS are expected to be at least 2
  localparam int UW = $clog2(NUM_UNITS);
  localparam int CW = $clog2(MAX_CHAINS);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] PAUSE  = 3'd1;
  localparam logic [2:0] SEND   = 3'd2;
  localparam logic [2:0] GAP    = 3'd3;
  localparam logic [2:0] FINISH = 3'd4;

  logic [2:0]                             state_q, state_d;
  logic [UW-1:0]                          unit_q, unit_d;
  logic [CW-1:0]                          chain_q, chain_d;
  logic [NUM_UNITS-1:0]                   pend_q, pend_d;
  logic [NUM_UNITS-1:0]                   dirty_q, sel, wr_hot, clr_hot;
  logic [NUM_UNITS-1:0][MAX_CHAINS-1:0][7:0] tbl;
  logic                                   wr_acc, in_range, start_acc, last_chain;

  function automatic logic [UW-1:0] first_set(input logic [NUM_UNITS-1:0] m);
    first_set = '0;
    for (int i = NUM_UNITS - 1; i >= 0; i--)
      if (m[i]) first_set = UW'(i);
  endfunction

  // wr_ready doubles as the "really idle" flag: it stays low for the first cycle out of reset
  assign wr_acc     = wr_valid && wr_ready;
  assign start_acc  = start && wr_ready;
  assign in_range   = {24'd0, wr_unit} < 32'(NUM_UNITS);
  assign wr_hot     = (wr_acc && in_range) ? (NUM_UNITS'(1) << wr_unit[UW-1:0]) : '0;
  assign last_chain = (chain_q == CW'(MAX_CHAINS - 1));
  assign clr_hot    = (state_q == SEND && last_chain) ? (NUM_UNITS'(1) << unit_q) : '0;

  // A write landing with start is folded into the selection so it goes out in this sequence
`ifdef CFG_SEND_DIRTY_ONLY_EN
  assign sel = dirty_q | wr_hot;
`else
  assign sel = '1;
`endif

  always_comb begin
    state_d = state_q;
    unit_d  = unit_q;
    chain_d = chain_q;
    pend_d  = pend_q;
    case (state_q)
      IDLE: begin
        if (start_acc) begin
          if (|sel) begin
            state_d = PAUSE;
            pend_d  = sel;
          end else begin
            state_d = FINISH;
          end
        end
      end
      PAUSE, GAP: begin
        if (|pend_q) begin
          state_d = SEND;
          unit_d  = first_set(pend_q);
          chain_d = '0;
        end else begin
          state_d = FINISH;
        end
      end
      SEND: begin
        if (last_chain) begin
          state_d = GAP;
          pend_d  = pend_q & ~clr_hot;
        end else begin
          chain_d = chain_q + 1'b1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      unit_q     <= '0;
      chain_q    <= '0;
      pend_q     <= '0;
      dirty_q    <= '0;
      tbl        <= '0;
      err        <= 1'b0;
      wr_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      tracing    <= 1'b1;
      configId   <= IDLE_ID;
      configData <= 8'h00;
    end else begin
      state_q <= state_d;
      unit_q  <= unit_d;
      chain_q <= chain_d;
      pend_q  <= pend_d;
      dirty_q <= (dirty_q | wr_hot) & ~clr_hot;
      if (wr_acc && in_range) tbl[wr_unit[UW-1:0]][wr_chain] <= wr_data;
      if (wr_acc && !in_range) err <= 1'b1;
      else if (start_acc)      err <= 1'b0;
      // Outputs are registered from the next state so they line up with the state they describe
      wr_ready   <= (state_d == IDLE);
      busy       <= (state_d == PAUSE) || (state_d == SEND) || (state_d == GAP);
      done       <= (state_d == FINISH);
      tracing    <= (state_d == IDLE) || (state_d == FINISH);
      configId   <= (state_d == SEND) ? 8'(unit_d) : IDLE_ID;
      configData <= (state_d == SEND) ? tbl[unit_d][chain_d] : 8'h00;
    end
  end

endmodule
